// File: rtl/qrd_pkg.sv
// Shared constants and types for the QRD row feeder: sample format, schedule
// length, identity value and the feed FSM state encoding.
package qrd_pkg;
    localparam int IN_WIDTH    = 14;
    localparam int FRAC_BITS   = 10;
    localparam int H_SIZE      = 4;
    localparam int TOTAL_STEPS = 22;
    localparam int N_ELEM      = H_SIZE * H_SIZE;
    localparam int IDX_W       = $clog2(N_ELEM);
    localparam int COL_W       = $clog2(H_SIZE);
    localparam int STEP_W      = $clog2(TOTAL_STEPS);
    localparam logic signed [IN_WIDTH-1:0] IDENT_VAL = IN_WIDTH'(1 << FRAC_BITS);

    typedef struct packed {
        logic signed [IN_WIDTH-1:0] re;
        logic signed [IN_WIDTH-1:0] im;
    } cplx_t;

    typedef enum logic {ST_IDLE = 1'b0, ST_FEED = 1'b1} feed_state_t;
endpackage

// File: rtl/qrd_mat_bank.sv
// One 4x4 complex matrix bank: raster-indexed write port, and one combinational
// read per matrix row so all four skewed rows can be fetched in the same cycle.
module qrd_mat_bank
    import qrd_pkg::*;
(
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  cplx_t            wr_data,
    input  logic [COL_W-1:0] rd_col  [H_SIZE],
    output cplx_t            rd_data [H_SIZE]
);
    cplx_t mem_q [N_ELEM];
    cplx_t mem_d [N_ELEM];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[wr_idx] = wr_data;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Read port r always addresses matrix row r.
    always_comb begin
        for (int r = 0; r < H_SIZE; r++)
            rd_data[r] = mem_q[{COL_W'(r), rd_col[r]}];
    end
endmodule

// File: rtl/qrd_row_feeder.sv
// Ping-pong loader for 4x4 complex H plus the staggered [H | I] row schedule
// feeding the QRD core, with stall on the core's in_ready.
module qrd_row_feeder
    import qrd_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic signed [IN_WIDTH-1:0] s_data_r,
    input  logic signed [IN_WIDTH-1:0] s_data_i,
    input  logic                       in_ready,
    output logic signed [IN_WIDTH-1:0] row_in_1_r,
    output logic signed [IN_WIDTH-1:0] row_in_1_i,
    output logic signed [IN_WIDTH-1:0] row_in_2_r,
    output logic signed [IN_WIDTH-1:0] row_in_2_i,
    output logic signed [IN_WIDTH-1:0] row_in_3_r,
    output logic signed [IN_WIDTH-1:0] row_in_3_i,
    output logic signed [IN_WIDTH-1:0] row_in_4_r,
    output logic signed [IN_WIDTH-1:0] row_in_4_i,
    output logic                       row_in_1_f,
    output logic                       row_in_2_f,
    output logic                       row_in_3_f,
    output logic                       busy
);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(TOTAL_STEPS - 1);

    feed_state_t       state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              rptr_q, rptr_d;
    logic              wptr_q, wptr_d;
    logic [1:0]        full_q, full_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              s_ready_q, s_ready_d;
    logic              busy_q, busy_d;
    cplx_t             row_q [H_SIZE];
    cplx_t             row_d [H_SIZE];
    logic [2:0]        flag_q, flag_d;

    logic              accept;
    logic [1:0]        bank_we;
    cplx_t             wr_data;
    logic [COL_W-1:0]  rd_col    [H_SIZE];
    cplx_t             rd_data_0 [H_SIZE];
    cplx_t             rd_data_1 [H_SIZE];

    logic              load, zero_out, free_bank, sel_bank;
    logic [STEP_W-1:0] sel_step;
    cplx_t             sched [H_SIZE];
    logic [2:0]        sched_flag;
    int                lidx;

    qrd_mat_bank u_bank0 (
        .clk     (clk),
        .wr_en   (bank_we[0]),
        .wr_idx  (cnt_q),
        .wr_data (wr_data),
        .rd_col  (rd_col),
        .rd_data (rd_data_0)
    );

    qrd_mat_bank u_bank1 (
        .clk     (clk),
        .wr_en   (bank_we[1]),
        .wr_idx  (cnt_q),
        .wr_data (wr_data),
        .rd_col  (rd_col),
        .rd_data (rd_data_1)
    );

    // Load side: s_ready is registered so a freed bank is writable one cycle later.
    always_comb begin
        accept  = s_valid && s_ready_q;
        wr_data = '{re: s_data_r, im: s_data_i};
        bank_we = '0;
        cnt_d   = cnt_q;
        wptr_d  = wptr_q;
        full_d  = full_q;
        if (accept) begin
            bank_we[wptr_q] = 1'b1;
            if (cnt_q == IDX_W'(N_ELEM - 1)) begin
                full_d[wptr_q] = 1'b1;
                wptr_d         = ~wptr_q;
                cnt_d          = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (free_bank) full_d[rptr_q] = 1'b0;
        s_ready_d = !full_d[wptr_d];
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        rptr_d    = rptr_q;
        load      = 1'b0;
        zero_out  = 1'b0;
        free_bank = 1'b0;
        sel_bank  = rptr_q;
        sel_step  = '0;
        case (state_q)
            ST_IDLE: begin
                if (full_q[rptr_q]) begin
                    load    = 1'b1;
                    step_d  = '0;
                    state_d = ST_FEED;
                end
            end
            ST_FEED: begin
                if (in_ready) begin
                    if (step_q != LAST_STEP) begin
                        sel_step = step_q + 1'b1;
                        step_d   = sel_step;
                        load     = 1'b1;
                    end else begin
                        free_bank = 1'b1;
                        rptr_d    = ~rptr_q;
                        if (full_q[~rptr_q]) begin
                            load     = 1'b1;
                            sel_bank = ~rptr_q;
                            step_d   = '0;
                        end else begin
                            zero_out = 1'b1;
                            state_d  = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        for (int r = 0; r < H_SIZE; r++)
            rd_col[r] = COL_W'(sel_step - STEP_W'(r));
    end

    // Row r lags by r steps; columns 0..3 come from H, 4..7 are the identity half.
    always_comb begin
        lidx = 0;
        for (int r = 0; r < H_SIZE; r++) begin
            lidx     = int'(sel_step) - r;
            sched[r] = '0;
            if (lidx >= 0 && lidx < H_SIZE)
                sched[r] = sel_bank ? rd_data_1[r] : rd_data_0[r];
            else if (lidx == H_SIZE + r)
                sched[r].re = IDENT_VAL;
        end
        sched_flag = {sel_step == STEP_W'(4), sel_step == STEP_W'(2), sel_step == STEP_W'(0)};
    end

    always_comb begin
        row_d  = row_q;
        flag_d = flag_q;
        if (load) begin
            row_d  = sched;
            flag_d = sched_flag;
        end else if (zero_out) begin
            row_d  = '{default: '0};
            flag_d = '0;
        end
        busy_d = (state_d == ST_FEED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            step_q    <= '0;
            rptr_q    <= 1'b0;
            wptr_q    <= 1'b0;
            full_q    <= '0;
            cnt_q     <= '0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            row_q     <= '{default: '0};
            flag_q    <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            rptr_q    <= rptr_d;
            wptr_q    <= wptr_d;
            full_q    <= full_d;
            cnt_q     <= cnt_d;
            s_ready_q <= s_ready_d;
            busy_q    <= busy_d;
            row_q     <= row_d;
            flag_q    <= flag_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign busy       = busy_q;
    assign row_in_1_r = row_q[0].re;
    assign row_in_1_i = row_q[0].im;
    assign row_in_2_r = row_q[1].re;
    assign row_in_2_i = row_q[1].im;
    assign row_in_3_r = row_q[2].re;
    assign row_in_3_i = row_q[2].im;
    assign row_in_4_r = row_q[3].re;
    assign row_in_4_i = row_q[3].im;
    assign row_in_1_f = flag_q[0];
    assign row_in_2_f = flag_q[1];
    assign row_in_3_f = flag_q[2];
endmodule

// File: doc/qrd_row_feeder.md
Name: qrd_row_feeder

Overview:
- Front-end transmitter for the QRD core. Accepts 4x4 complex H matrices as a raster stream over a valid/ready port.
- Augments each matrix with a 4x4 identity, [H | I], and drives the core's four skewed row inputs and start flags.
- Generates the 22-step staggered schedule the core consumes, stalling on the core's in_ready.
- Ping-pong buffered: the next matrix loads while the current one is fed.

Parameters:
IN_WIDTH, 14, bit width of each real/imag sample (signed two's complement)
FRAC_BITS, 10, fraction bits; identity diagonal value = 2^FRAC_BITS (1024)
H_SIZE, 4, matrix dimension (fixed; 4 is the only supported value)
TOTAL_STEPS, 22, schedule steps per frame, including trailing zero padding

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
s_valid  in  1  input element valid
s_ready  out  1  feeder can accept an element
s_data_r  in  IN_WIDTH  H element, real part, row-major order (H[0][0], H[0][1], ... H[3][3])
s_data_i  in  IN_WIDTH  H element, imaginary part
in_ready  in  1  core ready; schedule advances only when high
row_in_1_r/_i .. row_in_4_r/_i  out  IN_WIDTH each  skewed row samples to the core
row_in_1_f, row_in_2_f, row_in_3_f  out  1 each  row start flags
busy  out  1  frame currently being fed

Behaviour:
- Reset (async, rst=1): all outputs 0, s_ready=0, both banks empty, write pointer = bank 0, FSM = IDLE. s_ready rises in the first cycle after rst deasserts.
- Load side:
  - Two banks of 16 complex registers each, write pointer wptr, element counter 0..15.
  - s_ready = !full[wptr] (registered flags only).
  - An element is accepted on an edge where s_valid && s_ready. Counter increments.
  - When counter reaches 15: full[wptr] is set, wptr toggles, counter returns to 0.
- Schedule, with A = [H | I] (A[r][c+4] = 1024 if r==c else 0; imag of the identity half = 0):
  - row1 = A[0][l] for 0<=l<=7
  - row2 = A[1][l-1] for 1<=l<=8
  - row3 = A[2][l-2] for 2<=l<=9
  - row4 = A[3][l-3] for 3<=l<=10
  - every sample is 0 outside its range
  - row_in_1_f = (l==0), row_in_2_f = (l==2), row_in_3_f = (l==4)
- Feed FSM, states IDLE and FEED, read pointer rptr; all row outputs are registered:
  - IDLE: row outputs 0, flags 0, busy=0. On an edge with full[rptr]=1: load step-0 values from bank rptr, step=0, go to FEED.
  - FEED, in_ready=0: hold step and all outputs unchanged.
  - FEED, in_ready=1, step<TOTAL_STEPS-1: step+1, load that step's values.
  - FEED, in_ready=1, step==TOTAL_STEPS-1: clear full[rptr], toggle rptr.
    - If the other bank is full: load its step-0 values and stay in FEED (back-to-back, no bubble).
    - Otherwise: load zeros and go to IDLE.
- Latency: the last H element accepted at edge E puts step 0 on the outputs after E+1 if the feeder was idle.
- Boundary conditions:
  - Both banks full: s_ready=0; s_valid is ignored.
  - Bank freed and load requested in the same cycle: a write to the freed bank is allowed from the next cycle (s_ready sees the registered flag).
  - Data is never overwritten while that bank is being fed.
  - s_valid low mid-matrix: counter holds; no timeout.
  - rst mid-frame: partial load and in-flight frame are discarded, outputs forced to 0 immediately.
- Arithmetic: pure data movement; no width growth. Identity constant = 1 << FRAC_BITS, truncated to IN_WIDTH (1024 fits in 14 bits).

Decomposition:
- Shared package qrd_pkg: IN_WIDTH, FRAC_BITS, H_SIZE, TOTAL_STEPS, identity constant, complex sample type, FSM state enum.
- One sub-module: qrd_mat_bank. Holds one 16-entry complex register bank, with a write port (index, data, enable) and a combinational read at (row, col). Instantiated twice.
- Schedule decode (step to per-row column index, zero mask, flags) stays in the top module.

Test Plan:
- Single frame, in_ready always 1:
  - Stimulus: H[r][c] = (16r+c) + j(-(16r+c)).
  - Required: step 0 gives row1=0+0j, f1=1. Step 2 gives row2=A[1][1]=17-17j, f2=1.
  - Step 4 gives row1=A[0][4]=1024+0j, row3=A[2][2]=34-34j, f3=1.
  - Steps 11..21 are all zeros; busy falls after step 21.
- Stall: hold in_ready=0 for 3 cycles at step 5. Required: outputs frozen at step-5 values (row1=A[0][5]=0, row4=A[3][2]=50-50j); schedule resumes at step 6.
- Back-to-back: load two matrices with in_ready always 1. Required: frame 2 step 0 follows frame 1 step 21 with no idle cycle, and frame 2 data is uncorrupted.
- Backpressure: load 3 matrices while in_ready=0. Required: s_ready drops after the 32nd accepted element; the 33rd is accepted only after frame 1 finishes step 21.
- Reset at step 10 of a frame with the other bank half-loaded. Required: all outputs 0 immediately; busy=0.
  - After release: s_ready=1 with bank 0 targeted; a fresh matrix feeds correctly from step 0.
- Load gaps: random s_valid gaps during a load. Required: elements land in row-major order (verified through row4 at steps 3..6 = A[3][0..3]).
